uart_tx: RTL
============

# uart_tx

UART transmitter for the same serial link the UART receiver terminates. Accepts a parallel byte on a valid/busy handshake and drives one frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. Each bit is held for Prescale clock cycles, so a receiver clocked at the same rate with the same Prescale samples mid-bit.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- PRESCALE_WIDTH, 6: width of Prescale and of the in-bit cycle counter.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- P_DATA  in  DATA_WIDTH  byte to send. Sampled only on accept.
- DATA_VALID  in  1  request; a frame is accepted when DATA_VALID=1 and Busy=0.
- PAR_EN  in  1  1 = parity bit inserted. Sampled on accept.
- PAR_TYP  in  1  0 = even, 1 = odd. Sampled on accept.
- Prescale  in  PRESCALE_WIDTH  CLK cycles per bit. Legal range 4..2^PRESCALE_WIDTH-1. Sampled on accept.
- TX_OUT  out  1  serial line, idle high.
- Busy  out  1  high while a frame is in flight.

## Operation
- States: IDLE, START, DATA, PAR, STOP. Encoding is defined in the package.
- IDLE: TX_OUT=1, Busy=0. On accept, latch P_DATA, PAR_EN, PAR_TYP and Prescale into shadow registers, compute the parity bit, clear the counters, and go to START.
- Parity bit = ^data for even, ~^data for odd, computed over the latched data.
- START: TX_OUT=0 for Prescale cycles, then DATA.
- DATA: TX_OUT=data[bit_cnt], with bit_cnt running 0..DATA_WIDTH-1. Each bit lasts Prescale cycles. After the last bit, go to PAR if the latched PAR_EN=1, otherwise to STOP.
- PAR: TX_OUT=parity bit for Prescale cycles, then STOP.
- STOP: TX_OUT=1 for Prescale cycles, then IDLE.
- Cycle counter runs 0..Prescale-1 and wraps at Prescale-1. A bit or state transition happens only on the wrap.
- bit_cnt is $clog2(DATA_WIDTH) bits wide. It increments only in DATA on the wrap and clears on entry to DATA.
- Input changes during a frame have no effect. Only the shadow registers are used.
- DATA_VALID while Busy=1 is ignored and not queued. The requester holds DATA_VALID until it sees Busy rise.
- Unused state encodings recover to IDLE with TX_OUT=1, Busy=0.

## Timing
- Reset values: state IDLE, TX_OUT=1, Busy=0, counters 0, shadow registers 0.
- RST during a frame: the next edge forces IDLE, TX_OUT=1, Busy=0. The partial frame is dropped.
- TX_OUT and Busy are registered, with no combinational path from any input.
- Accept at edge k. The start bit appears on TX_OUT and Busy rises at edge k+1.
- Frame length is F = (2 + DATA_WIDTH + P) × Prescale cycles, where P is the latched PAR_EN.
- Busy stays high for exactly F cycles, from edge k+1 to edge k+1+F, and falls together with the return to IDLE.
- Minimum frame-to-frame spacing is F+1 cycles: one idle-high cycle between stop and the next start. With DATA_VALID held high, frames repeat at exactly this spacing.

## Configuration
- UART_TX_PARITY_EN defined: the PAR state, parity logic and PAR_EN/PAR_TYP shadow registers exist, and behaviour is as above.
- UART_TX_PARITY_EN undefined: the PAR state and parity logic are removed. PAR_EN and PAR_TYP remain as ports but are ignored, and DATA always goes to STOP. Frame length is then (2+DATA_WIDTH)×Prescale.

## Structure
- Package uart_pkg holds the state encoding constants (IDLE, START, DATA, PAR, STOP) and the parity type constants (PAR_EVEN=0, PAR_ODD=1). It is shared with the receiver side.
- One sub-module, uart_tx_parity_calc: combinational parity over DATA_WIDTH bits plus PAR_TYP. It is instantiated only under UART_TX_PARITY_EN.
- The counters, FSM and output register live in uart_tx.

## Test plan
- Reset release, no request: TX_OUT=1 and Busy=0 for 100 cycles. RST asserted mid-DATA: next edge TX_OUT=1, Busy=0.
- P_DATA=0xA5, PAR_EN=0, Prescale=8: TX_OUT sequence is 0,1,0,1,0,0,1,0,1,1, each bit for 8 cycles. Busy is high for 80 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=16: parity bit 0 follows the data. Busy lasts 176 cycles. With PAR_TYP=1 the parity bit is 1.
- DATA_VALID held high with two bytes 0x00 then 0xFF, Prescale=4: second start bit begins exactly 41 cycles after the first. Change P_DATA mid-frame: the transmitted byte is unchanged.
- Prescale changed from 8 to 32 mid-frame: current frame stays at 8 cycles per bit. Next frame uses 32.
- Build without UART_TX_PARITY_EN, PAR_EN=1, P_DATA=0x3C, Prescale=8: no parity bit is sent and Busy lasts 80 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-type constants,
// used by both the transmitter and the receiver side of the link.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake plus serial output bundle between a requester (master)
// and the UART transmitter (slave).
interface uart_tx_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
);
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      DATA_VALID;
   logic                      PAR_EN;
   logic                      PAR_TYP;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      TX_OUT;
   logic                      Busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
      input  TX_OUT, Busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
      output TX_OUT, Busy
   );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity over a data word; par_typ selects even or odd.
module uart_tx_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit (only built when UART_TX_PARITY_EN is defined), one stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic     CLK,
   input  logic     RST,
   uart_tx_if.slave bus
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_e               state, state_nxt;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [PRESCALE_WIDTH-1:0] cnt;
   logic [BW-1:0]             bit_cnt;
   logic                      tx_q, busy_q, tx_d, busy_d;
   logic                      accept, wrap, last_bit;

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_typ_q, par_bit;

   uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data    (data_q),
      .par_typ (par_typ_q),
      .par_bit (par_bit)
   );
`else
   logic unused_par_inputs;
   assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
`endif

   // Accept is keyed on the FSM being idle, so back-to-back requests get
   // exactly one idle-high cycle between the stop bit and the next start.
   assign accept   = (state == IDLE) && bus.DATA_VALID;
   assign wrap     = (cnt == presc_q - PRESCALE_WIDTH'(1));
   assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.DATA_VALID) state_nxt = START;
         START: if (wrap) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:  if (wrap && last_bit) state_nxt = par_en_q ? PAR : STOP;
         PAR:   if (wrap) state_nxt = STOP;
`else
         DATA:  if (wrap && last_bit) state_nxt = STOP;
`endif
         STOP:  if (wrap) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state)
         IDLE:  busy_d = 1'b0;
         START: tx_d   = 1'b0;
         DATA:  tx_d   = data_q[bit_cnt];
`ifdef UART_TX_PARITY_EN
         PAR:   tx_d   = par_bit;
`endif
         STOP:  tx_d   = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   // NOTE: RST is synchronous, so it is tested inside the clocked block and
   // never appears in the sensitivity list; shadow registers are cleared too.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         bit_cnt <= '0;
         data_q  <= '0;
         presc_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
`endif
      end else if (accept) begin
         cnt     <= '0;
         bit_cnt <= '0;
         data_q  <= bus.P_DATA;
         presc_q <= bus.Prescale;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= bus.PAR_EN;
         par_typ_q <= bus.PAR_TYP;
`endif
      end else if (state != IDLE) begin
         cnt <= wrap ? '0 : cnt + PRESCALE_WIDTH'(1);
         if (state == START)         bit_cnt <= '0;
         else if (state == DATA && wrap) bit_cnt <= bit_cnt + BW'(1);
      end
   end

   // Outputs are registered from the current state, so the line lags the
   // FSM by one cycle and has no combinational path from any input.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= busy_d;
      end
   end

   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;

endmodule
